// File: rtl/control_sequencer_if.sv
// Control bundle between the T-state sequencer and the datapath / memory / register-select logic.
// Latency: wires only; no state.
// Backpressure: mem_ready is the only return path; it stalls the sequencer in its wait states.
interface control_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic        mem_ready;

    logic        PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, Cout;
    logic        MDRin, MDRout, IRin, Read, Write;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic [3:0]  alu_op;
    logic        run;
    logic        illegal;
    logic        mem_err;

    modport master (
        input  start, ir, mem_ready,
        output PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, Cout,
        output MDRin, MDRout, IRin, Read, Write,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output alu_op, run, illegal, mem_err
    );

    modport slave (
        output start, ir, mem_ready,
        input  PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, Cout,
        input  MDRin, MDRout, IRin, Read, Write,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  alu_op, run, illegal, mem_err
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-state controller driving datapath, memory and register-select strobes.
// Latency: strobes are a Moore decode of the state register; 3-cycle fetch, 6/8/3 cycles per instruction.
// Backpressure: fetch T1, ld T6 and st T7 hold on mem_ready; WAIT_MAX stalled cycles set sticky mem_err and halt.
module control_sequencer #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic [4:0] opc;
    logic       is_alu, is_imm, is_ldi, is_ld, is_st, is_nop, is_halt, is_addr, is_exec;
    logic       is_wait, timeout;
    logic [3:0] alu_sel;
    logic       unused_ir;

    // Only the opcode steers control; register fields and C go straight to the datapath.
    assign opc       = bus.ir[31:27];
    assign unused_ir = ^bus.ir[26:0];

    assign is_alu  = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    assign is_imm  = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI);
    assign is_ldi  = (opc == OP_LDI);
    assign is_ld   = (opc == OP_LD);
    assign is_st   = (opc == OP_ST);
    assign is_nop  = (opc == OP_NOP);
    assign is_halt = (opc == OP_HALT);
    assign is_addr = is_ldi || is_ld || is_st;
    assign is_exec = is_alu || is_imm || is_addr;

    // A wait state is one that holds for mem_ready; the counter only runs while stalled there.
    assign is_wait = (state_q == S_T1) || ((state_q == S_T6) && is_ld) || ((state_q == S_T7) && is_st);
    assign timeout = is_wait && !bus.mem_ready && ((wait_cnt_q + 8'd1) == WAIT_LIM);

    // ALU function for register and immediate forms; address arithmetic always adds.
    always_comb begin
        alu_sel = ALU_ADD;
        case (opc)
            OP_SUB:          alu_sel = ALU_SUB;
            OP_AND, OP_ANDI: alu_sel = ALU_AND;
            OP_OR, OP_ORI:   alu_sel = ALU_OR;
            default:         alu_sel = ALU_ADD;
        endcase
    end

    // Next state, wait counter and sticky error.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = (is_wait && !bus.mem_ready) ? wait_cnt_q + 8'd1 : 8'd0;
        mem_err_d  = mem_err_q || timeout;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_ready) state_d = S_T2;
            S_T2:   state_d = is_nop ? S_T0 : (is_halt ? S_HALT : S_T3);
            S_T3:   state_d = is_exec ? S_T4 : S_T0;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_ld || is_st) ? S_T6 : S_T0;
            S_T6:   if (!(is_ld && !bus.mem_ready)) state_d = S_T7;
            S_T7:   if (!(is_st && !bus.mem_ready)) state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_HALT;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Moore strobe decode; ir is read from T3 on, after IRin has loaded the new word.
    always_comb begin
        bus.PCout = 1'b0; bus.MARin = 1'b0; bus.IncPC = 1'b0; bus.PCin = 1'b0;
        bus.Zin = 1'b0; bus.Zlowout = 1'b0; bus.Yin = 1'b0; bus.Cout = 1'b0;
        bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
        bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
        bus.alu_op  = ALU_ADD;
        bus.illegal = 1'b0;
        bus.run     = (state_q != S_IDLE) && (state_q != S_HALT);
        bus.mem_err = mem_err_q;
        case (state_q)
            S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
            S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: begin
                if (is_exec) begin
                    bus.Grb   = 1'b1;
                    bus.Yin   = 1'b1;
                    bus.Rout  = is_alu || is_imm;
                    bus.BAout = is_addr;
                end else begin
                    bus.illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_exec) begin
                    bus.Zin    = 1'b1;
                    bus.Grc    = is_alu;
                    bus.Rout   = is_alu;
                    bus.Cout   = !is_alu;
                    bus.alu_op = (is_alu || is_imm) ? alu_sel : ALU_ADD;
                end
            end
            S_T5: begin
                if (is_exec) begin
                    bus.Zlowout = 1'b1;
                    bus.MARin   = is_ld || is_st;
                    bus.Gra     = !(is_ld || is_st);
                    bus.Rin     = !(is_ld || is_st);
                end
            end
            S_T6: begin
                if (is_ld) begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                else if (is_st) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
            end
            S_T7: begin
                if (is_ld) begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                else if (is_st) bus.Write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected strobes queued per instruction, popped each cycle.
// Latency: one comparison per clock, sampled 1 ns after the rising edge.
// Backpressure: mem_ready stalls and timeouts are scripted per instruction.
module tb_control_sequencer;
    localparam int TB_WAIT = 4;

    localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4;
    localparam logic [4:0] OP_AND = 5'd5, OP_OR = 5'd6, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14;
    localparam logic [4:0] OP_NOP = 5'd26, OP_HALT = 5'd27;

    // Strobe bit positions, MSB first: PCout..BAout.
    localparam logic [18:0] B_PCOUT = 19'd1 << 18, B_MARIN = 19'd1 << 17, B_INCPC = 19'd1 << 16;
    localparam logic [18:0] B_PCIN = 19'd1 << 15, B_ZIN = 19'd1 << 14, B_ZLOWOUT = 19'd1 << 13;
    localparam logic [18:0] B_YIN = 19'd1 << 12, B_COUT = 19'd1 << 11, B_MDRIN = 19'd1 << 10;
    localparam logic [18:0] B_MDROUT = 19'd1 << 9, B_IRIN = 19'd1 << 8, B_READ = 19'd1 << 7;
    localparam logic [18:0] B_WRITE = 19'd1 << 6, B_GRA = 19'd1 << 5, B_GRB = 19'd1 << 4;
    localparam logic [18:0] B_GRC = 19'd1 << 3, B_RIN = 19'd1 << 2, B_ROUT = 19'd1 << 1, B_BAOUT = 19'd1;

    localparam logic [18:0] ST_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [18:0] ST_T1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [18:0] ST_T2 = B_MDROUT | B_IRIN;
    localparam logic [18:0] ST_RB = B_GRB | B_ROUT | B_YIN;
    localparam logic [18:0] ST_BA = B_GRB | B_BAOUT | B_YIN;
    localparam logic [18:0] ST_RC = B_GRC | B_ROUT | B_ZIN;
    localparam logic [18:0] ST_CZ = B_COUT | B_ZIN;
    localparam logic [18:0] ST_WB = B_ZLOWOUT | B_GRA | B_RIN;
    localparam logic [18:0] ST_MA = B_ZLOWOUT | B_MARIN;
    localparam logic [18:0] ST_L6 = B_READ | B_MDRIN;
    localparam logic [18:0] ST_L7 = B_MDROUT | B_GRA | B_RIN;
    localparam logic [18:0] ST_S6 = B_GRA | B_ROUT | B_MDRIN;
    localparam logic [18:0] ST_S7 = B_WRITE;

    typedef struct packed {
        logic [18:0] strb;
        logic [3:0]  alu_op;
        logic        run;
        logic        illegal;
        logic        mem_err;
    } out_t;

    typedef struct {
        out_t  e;
        logic  rdy;
        string tag;
    } sb_t;

    typedef struct {
        logic [31:0] ir;
        int          fd;
        int          md;
        int          cycles;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   errs = 0;
    sb_t  sb_q[$];
    vec_t vecs[13];
    logic [4:0] legal_ops[11];

    control_sequencer_if bus();
    control_sequencer #(.WAIT_MAX(TB_WAIT)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] exp_alu(input logic [4:0] op);
        case (op)
            OP_SUB:          return 4'b0001;
            OP_AND, OP_ANDI: return 4'b0010;
            OP_OR, OP_ORI:   return 4'b0011;
            default:         return 4'b0000;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [4:0] op);
        if (op == OP_LD || op == OP_ST) return 8;
        if (op == OP_NOP) return 3;
        return 6;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.strb = {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Zin, bus.Zlowout, bus.Yin, bus.Cout,
                  bus.MDRin, bus.MDRout, bus.IRin, bus.Read, bus.Write,
                  bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout};
        o.alu_op  = bus.alu_op;
        o.run     = bus.run;
        o.illegal = bus.illegal;
        o.mem_err = bus.mem_err;
        return o;
    endfunction

    task automatic push(input logic [18:0] s, input logic [3:0] a, input logic ill, input logic rdy,
                        input string tag);
        sb_t x;
        x.e.strb = s; x.e.alu_op = a; x.e.run = 1'b1; x.e.illegal = ill; x.e.mem_err = 1'b0;
        x.rdy = rdy; x.tag = tag;
        sb_q.push_back(x);
    endtask

    // IDLE and HALT look alike: everything low apart from the sticky error.
    task automatic push_idle(input string tag, input logic err);
        sb_t x;
        x.e = '0; x.e.mem_err = err; x.rdy = rnd(); x.tag = tag;
        sb_q.push_back(x);
    endtask

    // n stalled cycles then a ready cycle; n < 0 means memory never answers.
    task automatic push_wait(input logic [18:0] s, input int n, input string tag);
        if (n < 0) begin
            for (int i = 0; i < TB_WAIT; i++) push(s, 4'd0, 1'b0, 1'b0, tag);
        end else begin
            for (int i = 0; i < n; i++) push(s, 4'd0, 1'b0, 1'b0, tag);
            push(s, 4'd0, 1'b0, 1'b1, tag);
        end
    endtask

    task automatic gen(input logic [31:0] irv, input int fd, input int md);
        logic [4:0] op;
        op = irv[31:27];
        push(ST_T0, 4'd0, 1'b0, rnd(), "T0");
        push_wait(ST_T1, fd, "T1");
        if (fd < 0) return;
        push(ST_T2, 4'd0, 1'b0, rnd(), "T2");
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                push(ST_RB, 4'd0, 1'b0, rnd(), "T3");
                push(ST_RC, exp_alu(op), 1'b0, rnd(), "T4");
                push(ST_WB, 4'd0, 1'b0, rnd(), "T5");
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                push(ST_RB, 4'd0, 1'b0, rnd(), "T3");
                push(ST_CZ, exp_alu(op), 1'b0, rnd(), "T4");
                push(ST_WB, 4'd0, 1'b0, rnd(), "T5");
            end
            OP_LDI: begin
                push(ST_BA, 4'd0, 1'b0, rnd(), "T3");
                push(ST_CZ, 4'd0, 1'b0, rnd(), "T4");
                push(ST_WB, 4'd0, 1'b0, rnd(), "T5");
            end
            OP_LD: begin
                push(ST_BA, 4'd0, 1'b0, rnd(), "T3");
                push(ST_CZ, 4'd0, 1'b0, rnd(), "T4");
                push(ST_MA, 4'd0, 1'b0, rnd(), "T5");
                push_wait(ST_L6, md, "ldT6");
                if (md >= 0) push(ST_L7, 4'd0, 1'b0, rnd(), "ldT7");
            end
            OP_ST: begin
                push(ST_BA, 4'd0, 1'b0, rnd(), "T3");
                push(ST_CZ, 4'd0, 1'b0, rnd(), "T4");
                push(ST_MA, 4'd0, 1'b0, rnd(), "T5");
                push(ST_S6, 4'd0, 1'b0, rnd(), "stT6");
                push_wait(ST_S7, md, "stT7");
            end
            OP_NOP, OP_HALT: ;
            default: push(19'd0, 4'd0, 1'b1, rnd(), "T3ill");
        endcase
    endtask

    // Compare this cycle's outputs with the head of the scoreboard, then drive the next edge's inputs.
    task automatic cyc(input logic st, input logic rs);
        sb_t  x;
        out_t got;
        got = sample();
        nvec++;
        if (sb_q.size() == 0) begin
            errs++;
            $display("FAIL sb_empty t=%0t got=%h required=nothing queued", $time, got);
            bus.mem_ready = 1'b0;
        end else begin
            x = sb_q.pop_front();
            if (got !== x.e) begin
                errs++;
                $display("FAIL %s t=%0t ir=%h got=%h required=%h", x.tag, $time, bus.ir, got, x.e);
            end
            bus.mem_ready = x.rdy;
        end
        nvec++;
        if ($countones(got.strb[5:3]) > 1 || (got.strb[2] && (got.strb[1] || got.strb[0])) ||
            (got.strb[7] && got.strb[6])) begin
            errs++;
            $display("FAIL invariant t=%0t got=%h required=exclusive strobes", $time, got.strb);
        end
        bus.start = st;
        reset     = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input logic st);
        while (sb_q.size() > 0) cyc(st, 1'b0);
    endtask

    // Leave HALT via reset and start a fresh fetch.
    task automatic recover(input logic err);
        push_idle("halt_rst", err);
        cyc(1'b0, 1'b1);
        push_idle("idle_after_rst", 1'b0);
        cyc(1'b1, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{32'h18918000, 0, 0, 6, "add"};
        vecs[1]  = '{32'h20918000, 1, 0, 6, "sub"};
        vecs[2]  = '{32'h28918000, 2, 0, 6, "and"};
        vecs[3]  = '{32'h30918000, 0, 0, 6, "or"};
        vecs[4]  = '{32'h60900005, 0, 0, 6, "addi"};
        vecs[5]  = '{32'h68900005, 3, 0, 6, "andi"};
        vecs[6]  = '{32'h70900005, 0, 0, 6, "ori"};
        vecs[7]  = '{32'h08800010, 0, 0, 6, "ldi"};
        vecs[8]  = '{32'h00900065, 0, 3, 8, "ld"};
        vecs[9]  = '{32'h10900065, 1, 2, 8, "st"};
        vecs[10] = '{32'hD0000000, 0, 0, 3, "nop"};
        vecs[11] = '{32'hB8000000, 0, 0, 4, "ill10111"};
        vecs[12] = '{32'hF8000000, 1, 0, 4, "ill11111"};
        legal_ops = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_NOP};

        reset = 1'b1; bus.start = 1'b0; bus.mem_ready = 1'b0; bus.ir = 32'd0;
        @(posedge clk);
        #1;
        push_idle("reset", 1'b0);     cyc(1'b0, 1'b1);
        push_idle("idle", 1'b0);      cyc(1'b0, 1'b0);
        push_idle("idle_hold", 1'b0); cyc(1'b0, 1'b0);
        push_idle("idle_go", 1'b0);   cyc(1'b1, 1'b0);

        // Table of single instructions, back to back from T0.
        foreach (vecs[v]) begin
            bus.ir = vecs[v].ir;
            gen(vecs[v].ir, vecs[v].fd, vecs[v].md);
            for (int k = 0; k < vecs[v].cycles + vecs[v].fd + vecs[v].md; k++) cyc(1'b0, 1'b0);
        end

        // halt: start pulses in HALT are ignored.
        bus.ir = 32'hD8000000;
        gen(bus.ir, 0, 0);
        drain(1'b0);
        for (int i = 0; i < 3; i++) begin push_idle("halt_start", 1'b0); cyc(1'b1, 1'b0); end
        recover(1'b0);

        // Reset during T4 of sub, then a clean add.
        bus.ir = 32'h20918000;
        push(ST_T0, 4'd0, 1'b0, rnd(), "T0");
        push(ST_T1, 4'd0, 1'b0, 1'b1, "T1");
        push(ST_T2, 4'd0, 1'b0, rnd(), "T2");
        push(ST_RB, 4'd0, 1'b0, rnd(), "T3");
        while (sb_q.size() > 0) cyc(1'b0, 1'b0);
        push(ST_RC, 4'b0001, 1'b0, rnd(), "subT4");
        cyc(1'b0, 1'b1);
        push_idle("idle_after_mid_rst", 1'b0);
        cyc(1'b1, 1'b0);
        bus.ir = 32'h18918000;
        gen(bus.ir, 0, 0);
        drain(1'b0);

        // Reset while the fetch is stalled in T1.
        bus.ir = 32'h00900065;
        push(ST_T0, 4'd0, 1'b0, rnd(), "T0");
        push(ST_T1, 4'd0, 1'b0, 1'b0, "T1");
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        push(ST_T1, 4'd0, 1'b0, 1'b0, "T1rst");
        cyc(1'b0, 1'b1);
        push_idle("idle_after_wait_rst", 1'b0);
        cyc(1'b1, 1'b0);

        // st whose write is never acknowledged: mem_err then HALT.
        bus.ir = 32'h10900065;
        gen(bus.ir, 0, -1);
        drain(1'b0);
        for (int i = 0; i < 2; i++) begin push_idle("st_timeout_halt", 1'b1); cyc(1'b1, 1'b0); end
        recover(1'b1);

        // Fetch never acknowledged.
        bus.ir = 32'h18918000;
        gen(bus.ir, -1, 0);
        drain(1'b0);
        push_idle("fetch_timeout_halt", 1'b1);
        cyc(1'b1, 1'b0);
        recover(1'b1);

        // Random legal instruction stream with random stalls and stray start pulses.
        for (int n = 0; n < 1000; n++) begin
            logic [4:0] op;
            int fd, md;
            op = legal_ops[$urandom_range(0, 10)];
            fd = int'($urandom_range(0, 3));
            md = (op == OP_LD || op == OP_ST) ? int'($urandom_range(0, 3)) : 0;
            bus.ir = {op, 27'($urandom)};
            gen(bus.ir, fd, md);
            for (int k = 0; k < exp_cycles(op) + fd + md; k++) cyc(rnd(), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
